// File: rtl/instr_decode_if.sv
// Upstream fetch handshake and downstream decoded-entry bus of the decode stage.
// slave is the decode stage itself; master is whatever drives and consumes it.
interface instr_decode_if #(parameter int ILL_CNT_W = 16);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_ir;
  logic [31:0]          in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr_ID;
  logic [4:0]           rs_idx;
  logic [4:0]           rt_idx;
  logic [4:0]           dst_idx;
  logic [31:0]          imm32;
  logic                 b_sel_imm;
  logic                 a_sel_rt;
  logic                 wr_en;
  logic                 illegal;
  logic [31:0]          out_pc_next;
  logic [ILL_CNT_W-1:0] ill_count;

  modport slave (
    input  flush, in_valid, in_ir, in_pc, out_ready,
    output in_ready, out_valid, instr_ID, rs_idx, rt_idx, dst_idx, imm32,
           b_sel_imm, a_sel_rt, wr_en, illegal, out_pc_next, ill_count
  );

  modport master (
    output flush, in_valid, in_ir, in_pc, out_ready,
    input  in_ready, out_valid, instr_ID, rs_idx, rt_idx, dst_idx, imm32,
           b_sel_imm, a_sel_rt, wr_en, illegal, out_pc_next, ill_count
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage ahead of the ALU: combinational decode of in_ir, captured into a
// 2-entry skid buffer so in_ready can be registered without losing throughput.
module instr_decode_stage #(
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter int          ILL_CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  instr_decode_if.slave bus
);
  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic        b_sel;
    logic        a_sel;
    logic        wr_en;
    logic        illegal;
    logic [31:0] pc_next;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} st_t;

  st_t                  st, st_n;
  dec_t                 dec, head, tail;
  logic                 rdy_q;
  logic [ILL_CNT_W-1:0] ill_q;
  logic                 accept, xfer;
  logic                 head_ld_dec, head_ld_tail, tail_ld;

  wire [5:0] op    = bus.in_ir[31:26];
  wire [5:0] funct = bus.in_ir[5:0];

  always_comb begin
    dec         = '0;
    dec.rs      = bus.in_ir[25:21];
    dec.rt      = bus.in_ir[20:16];
    dec.pc_next = bus.in_pc + PC_STEP;
    case (op)
      6'h00: begin
        dec.dst = bus.in_ir[15:11];
        case (funct)
          6'h20: dec.id = 4'd1;
          6'h22: dec.id = 4'd2;
          6'h21: dec.id = 4'd3;
          6'h23: dec.id = 4'd4;
          6'h24: dec.id = 4'd7;
          6'h25: dec.id = 4'd8;
          6'h00, 6'h02: begin
            dec.id    = (funct == 6'h00) ? 4'd11 : 4'd12;
            dec.a_sel = 1'b1;
            dec.b_sel = 1'b1;
            dec.imm   = {27'b0, bus.in_ir[10:6]};
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin
        dec.id    = (op == 6'h08) ? 4'd5 : 4'd6;
        dec.dst   = bus.in_ir[20:16];
        dec.b_sel = 1'b1;
        dec.imm   = {{16{bus.in_ir[15]}}, bus.in_ir[15:0]};
      end
      6'h0C, 6'h0D: begin
        dec.id    = (op == 6'h0C) ? 4'd9 : 4'd10;
        dec.dst   = bus.in_ir[20:16];
        dec.b_sel = 1'b1;
        dec.imm   = {16'b0, bus.in_ir[15:0]};
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal words keep only the raw register fields and the PC.
    if (dec.illegal) begin
      dec.id  = '0;
      dec.dst = '0;
      dec.imm = '0;
    end
    dec.wr_en = !dec.illegal && (dec.dst != 5'd0);
  end

  assign accept = bus.in_valid && rdy_q;
  assign xfer   = (st != EMPTY) && bus.out_ready;

  always_comb begin
    st_n         = st;
    head_ld_dec  = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld      = 1'b0;
    case (st)
      EMPTY: if (accept) begin st_n = ONE; head_ld_dec = 1'b1; end
      ONE: begin
        if (accept && xfer)       head_ld_dec = 1'b1;
        else if (accept)          begin st_n = TWO; tail_ld = 1'b1; end
        else if (xfer)            st_n = EMPTY;
      end
      TWO: if (xfer) begin st_n = ONE; head_ld_tail = 1'b1; end
      default: st_n = EMPTY;
    endcase
    if (bus.flush) begin
      st_n         = EMPTY;
      head_ld_dec  = 1'b0;
      head_ld_tail = 1'b0;
      tail_ld      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= EMPTY;
      rdy_q <= 1'b1;
      head  <= '0;
      tail  <= '0;
      ill_q <= '0;
    end else begin
      st    <= st_n;
      rdy_q <= (st_n != TWO);
      if (head_ld_dec)       head <= dec;
      else if (head_ld_tail) head <= tail;
      if (tail_ld)           tail <= dec;
      if (accept && !bus.flush && dec.illegal && (ill_q != '1))
        ill_q <= ill_q + 1'b1;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = (st != EMPTY);
  assign bus.instr_ID    = {28'b0, head.id};
  assign bus.rs_idx      = head.rs;
  assign bus.rt_idx      = head.rt;
  assign bus.dst_idx     = head.dst;
  assign bus.imm32       = head.imm;
  assign bus.b_sel_imm   = head.b_sel;
  assign bus.a_sel_rt    = head.a_sel;
  assign bus.wr_en       = head.wr_en;
  assign bus.illegal     = head.illegal;
  assign bus.out_pc_next = head.pc_next;
  assign bus.ill_count   = ill_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; a 3-bit illegal counter makes the
// saturation point reachable in a few words.
module tb_instr_decode_stage;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_decode_if #(.ILL_CNT_W(CW)) bus ();

  instr_decode_stage #(.PC_STEP(32'd4), .ILL_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ir, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_ir    = ir;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  // id, dst, imm, {b_sel, a_sel, wr_en, illegal}
  task automatic chk_dec(input string tag, input logic [31:0] id, input logic [4:0] dst,
                         input logic [31:0] imm, input logic [3:0] flags);
    chk({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, ".id"}, bus.instr_ID, id);
    chk({tag, ".dst"}, {27'b0, bus.dst_idx}, {27'b0, dst});
    chk({tag, ".imm"}, bus.imm32, imm);
    chk({tag, ".flags"}, {28'b0, bus.b_sel_imm, bus.a_sel_rt, bus.wr_en, bus.illegal},
        {28'b0, flags});
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ir     = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.id", bus.instr_ID, 32'd0);
    chk("rst.pc", bus.out_pc_next, 32'd0);
    chk("rst.cnt", {29'b0, bus.ill_count}, 32'd0);
    reset = 1'b1;
    step();
    chk("rst.ready", {31'b0, bus.in_ready}, 32'd1);

    bus.out_ready = 1'b1;
    send(32'h0022_1820, 32'h100);
    chk_dec("add", 32'd1, 5'd3, 32'd0, 4'b0010);
    chk("add.rs", {27'b0, bus.rs_idx}, 32'd1);
    chk("add.rt", {27'b0, bus.rt_idx}, 32'd2);
    chk("add.pc", bus.out_pc_next, 32'h104);

    send(32'h0022_1822, 32'h104);
    chk_dec("sub", 32'd2, 5'd3, 32'd0, 4'b0010);
    send(32'h0022_1825, 32'h108);
    chk_dec("or", 32'd8, 5'd3, 32'd0, 4'b0010);
    send(32'h2085_FFFF, 32'h10C);
    chk_dec("addi", 32'd5, 5'd5, 32'hFFFF_FFFF, 4'b1010);
    send(32'h3485_8000, 32'h110);
    chk_dec("ori", 32'd10, 5'd5, 32'h0000_8000, 4'b1010);
    send(32'h3085_8000, 32'h114);
    chk_dec("andi", 32'd9, 5'd5, 32'h0000_8000, 4'b1010);
    send(32'h0003_1100, 32'h118);
    chk_dec("sll", 32'd11, 5'd2, 32'd4, 4'b1110);
    send(32'h0003_1142, 32'h11C);
    chk_dec("srl", 32'd12, 5'd2, 32'd5, 4'b1110);
    send(32'h0000_0000, 32'h120);
    chk_dec("nop", 32'd11, 5'd0, 32'd0, 4'b1100);

    send(32'h8C22_0004, 32'h124);
    chk_dec("lw", 32'd0, 5'd0, 32'd0, 4'b0001);
    chk("lw.rs", {27'b0, bus.rs_idx}, 32'd1);
    chk("lw.rt", {27'b0, bus.rt_idx}, 32'd2);
    chk("lw.cnt", {29'b0, bus.ill_count}, 32'd1);

    // Flush from ONE with a simultaneous illegal accept: dropped and uncounted.
    bus.flush = 1'b1;
    send(32'h03E0_0008, 32'h128);
    bus.flush = 1'b0;
    chk("fl1.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl1.ready", {31'b0, bus.in_ready}, 32'd1);
    chk("fl1.cnt", {29'b0, bus.ill_count}, 32'd1);

    // Flush from TWO with in_valid high.
    bus.out_ready = 1'b0;
    send(32'h0022_1820, 32'h200);
    send(32'h0022_2020, 32'h204);
    chk("fl2.full", {31'b0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    send(32'h0022_2820, 32'h208);
    bus.flush = 1'b0;
    chk("fl2.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl2.ready", {31'b0, bus.in_ready}, 32'd1);

    // Stall: offer four words, only two fit.
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_ir    = 32'h0022_0020 | (32'(k + 4) << 11);
      bus.in_pc    = 32'h300 + 32'(k * 4);
      step();
      chk("stall.head_pc", bus.out_pc_next, 32'h304);
      chk("stall.ready", {31'b0, bus.in_ready}, (k == 0) ? 32'd1 : 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("drain0.dst", {27'b0, bus.dst_idx}, 32'd4);
    step();
    chk("drain1.valid", {31'b0, bus.out_valid}, 32'd1);
    chk("drain1.pc", bus.out_pc_next, 32'h308);
    chk("drain1.dst", {27'b0, bus.dst_idx}, 32'd5);
    chk("drain1.ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("drain2.valid", {31'b0, bus.out_valid}, 32'd0);

    // Saturation of the illegal counter at all-ones (7 for 3 bits).
    for (int k = 0; k < 6; k++) send(32'hFC00_0000, 32'h400);
    chk("sat.max", {29'b0, bus.ill_count}, 32'd7);
    send(32'h8C22_0004, 32'h404);
    chk("sat.hold", {29'b0, bus.ill_count}, 32'd7);

    send(32'h0022_1820, 32'hFFFF_FFFC);
    chk("wrap.pc", bus.out_pc_next, 32'h0);

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    send(32'h2085_FFFF, 32'h500);
    send(32'h0022_1820, 32'h504);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst.id", bus.instr_ID, 32'd0);
    chk("arst.pc", bus.out_pc_next, 32'd0);
    chk("arst.cnt", {29'b0, bus.ill_count}, 32'd0);
    #3;
    reset = 1'b1;
    step();
    chk("arst.ready", {31'b0, bus.in_ready}, 32'd1);
    chk("arst.empty", {31'b0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
